// File: rtl/rvc_fetch_expander.sv
// Fetch realignment buffer: turns 32-bit fetch words into a halfword stream,
// reassembles straddling 32-bit instructions and expands RV32C quadrant 0.
module rvc_fetch_expander #(
    parameter int XLEN      = 32,
    parameter int BUF_HW    = 4,
    parameter int EXPAND_Q0 = 1
) (
    input  logic                          iCLK,
    input  logic                          iRST_N,
    input  logic                          iFLUSH,
    input  logic [XLEN-1:0]               iFLUSH_PC,
    input  logic                          iF_VALID,
    input  logic [31:0]                   iF_WORD,
    output logic                          oF_READY,
    output logic                          oD_VALID,
    input  logic                          iD_READY,
    output logic [31:0]                   oD_INSTR,
    output logic [XLEN-1:0]               oD_PC,
    output logic                          oD_IS_C,
    output logic                          oD_ILLEGAL,
    output logic [$clog2(BUF_HW+1)-1:0]   oCOUNT
);
    localparam int PW = $clog2(BUF_HW);
    localparam int CW = $clog2(BUF_HW + 1);
    localparam logic [CW-1:0] READY_MAX = CW'(BUF_HW - 2);

    logic [15:0]     hwBuf [BUF_HW];
    logic [PW-1:0]   headReg, headNext, tailReg, tailNext;
    logic [CW-1:0]   countReg, countNext;
    logic [XLEN-1:0] pcReg, pcNext;
    logic            skipReg, skipNext;

    logic [15:0]     hwLo, hwHi;
    logic            isC, doPush, doPop;
    logic [CW-1:0]   need, pushAmt, popAmt;
    logic [PW-1:0]   headPlus1, tailPlus1;

    assign headPlus1 = headReg + PW'(1);
    assign tailPlus1 = tailReg + PW'(1);
    assign hwLo      = hwBuf[headReg];
    assign hwHi      = hwBuf[headPlus1];
    assign isC       = (hwLo[1:0] != 2'b11);
    assign need      = isC ? CW'(1) : CW'(2);

    // Ready looks only at the registered count, so a pop never frees space in the same cycle.
    assign oF_READY  = !iFLUSH && (countReg <= READY_MAX);
    assign oD_VALID  = (countReg >= need);
    assign doPush    = iF_VALID && oF_READY;
    assign doPop     = oD_VALID && iD_READY && !iFLUSH;
    assign pushAmt   = !doPush ? CW'(0) : (skipReg ? CW'(1) : CW'(2));
    assign popAmt    = doPop ? need : CW'(0);

    assign oD_PC     = pcReg;
    assign oCOUNT    = countReg;

    always_comb begin
        headNext  = headReg;
        tailNext  = tailReg;
        countNext = countReg;
        pcNext    = pcReg;
        skipNext  = skipReg;
        if (iFLUSH) begin
            headNext  = '0;
            tailNext  = '0;
            countNext = '0;
            pcNext    = iFLUSH_PC & ~XLEN'(1);
            skipNext  = iFLUSH_PC[1];
        end else begin
            countNext = countReg + pushAmt - popAmt;
            if (doPush) begin
                tailNext = skipReg ? tailPlus1 : tailReg + PW'(2);
                skipNext = 1'b0;
            end
            if (doPop) begin
                headNext = headReg + PW'(need);
                pcNext   = pcReg + (isC ? XLEN'(2) : XLEN'(4));
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            headReg  <= '0;
            tailReg  <= '0;
            countReg <= '0;
            pcReg    <= '0;
            skipReg  <= 1'b0;
        end else begin
            headReg  <= headNext;
            tailReg  <= tailNext;
            countReg <= countNext;
            pcReg    <= pcNext;
            skipReg  <= skipNext;
        end
    end

    // Halfword storage carries no reset: entries are only read once count covers them.
    always_ff @(posedge iCLK) begin
        if (doPush) begin
            if (skipReg) begin
                hwBuf[tailReg] <= iF_WORD[31:16];
            end else begin
                hwBuf[tailReg]   <= iF_WORD[15:0];
                hwBuf[tailPlus1] <= iF_WORD[31:16];
            end
        end
    end

    logic [2:0] func3;
    logic [4:0] rdP, rs1P;
    logic [9:0] imm10;
    logic [6:0] off7;

    always_comb begin
        func3      = hwLo[15:13];
        rdP        = {2'b01, hwLo[4:2]};
        rs1P       = {2'b01, hwLo[9:7]};
        imm10      = {hwLo[10:7], hwLo[12:11], hwLo[5], hwLo[6], 2'b00};
        off7       = {hwLo[5], hwLo[12:10], hwLo[6], 2'b00};
        oD_INSTR   = {16'h0, hwLo};
        oD_IS_C    = 1'b1;
        oD_ILLEGAL = 1'b0;
        if (!isC) begin
            oD_INSTR = {hwHi, hwLo};
            oD_IS_C  = 1'b0;
        end else if ((EXPAND_Q0 != 0) && (hwLo[1:0] == 2'b00)) begin
            case (func3)
                3'b000: begin
                    oD_INSTR   = {2'b00, imm10, 5'd2, 3'b000, rdP, 7'h13};
                    oD_ILLEGAL = (imm10 == 10'd0);
                end
                3'b010:  oD_INSTR = {5'b0, off7, rs1P, 3'b010, rdP, 7'h03};
                3'b110:  oD_INSTR = {5'b0, off7[6:5], rdP, rs1P, 3'b010, off7[4:0], 7'h23};
                default: oD_ILLEGAL = 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_rvc_fetch_expander.sv
// Scoreboard bench for rvc_fetch_expander: a halfword-stream reference model
// predicts every instruction; a negedge monitor compares whenever a pop occurs.
module tb_rvc_fetch_expander;
    localparam int XLEN      = 32;
    localparam int BUF_HW    = 4;
    localparam int EXPAND_Q0 = 1;
    localparam int CW        = $clog2(BUF_HW + 1);

    logic            iCLK = 1'b0;
    logic            iRST_N = 1'b0;
    logic            iFLUSH = 1'b0;
    logic [XLEN-1:0] iFLUSH_PC = '0;
    logic            iF_VALID = 1'b0;
    logic [31:0]     iF_WORD = '0;
    logic            oF_READY;
    logic            oD_VALID;
    logic            iD_READY = 1'b0;
    logic [31:0]     oD_INSTR;
    logic [XLEN-1:0] oD_PC;
    logic            oD_IS_C;
    logic            oD_ILLEGAL;
    logic [CW-1:0]   oCOUNT;

    rvc_fetch_expander #(.XLEN(XLEN), .BUF_HW(BUF_HW), .EXPAND_Q0(EXPAND_Q0)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iFLUSH(iFLUSH), .iFLUSH_PC(iFLUSH_PC),
        .iF_VALID(iF_VALID), .iF_WORD(iF_WORD), .oF_READY(oF_READY),
        .oD_VALID(oD_VALID), .iD_READY(iD_READY), .oD_INSTR(oD_INSTR),
        .oD_PC(oD_PC), .oD_IS_C(oD_IS_C), .oD_ILLEGAL(oD_ILLEGAL), .oCOUNT(oCOUNT)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        isC;
        logic        ill;
        int          hw;
    } exp_t;

    exp_t        expQ[$];
    logic [15:0] pendQ[$];
    logic [31:0] modelPc = 32'h0;
    logic        modelSkip = 1'b0;
    int          nChecks = 0;
    int          nFails = 0;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] req);
        nChecks++;
        if (act !== req) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
        end
    endfunction

    // Reference decode straight from the instruction-set field definitions.
    function automatic exp_t refDecode(logic [15:0] lo, logic [15:0] hi, logic [31:0] pc);
        exp_t e;
        int unsigned ir, f3, rdp, rs1p, imm, off;
        ir   = lo;
        f3   = (ir >> 13) & 7;
        rdp  = 8 + ((ir >> 2) & 7);
        rs1p = 8 + ((ir >> 7) & 7);
        e.pc = pc;
        e.ill = 1'b0;
        if ((ir & 3) == 3) begin
            e.instr = {hi, lo};
            e.isC = 1'b0;
            e.hw = 2;
            return e;
        end
        e.isC = 1'b1;
        e.hw = 1;
        e.instr = ir;
        if ((ir & 3) == 0 && EXPAND_Q0 != 0) begin
            imm = (((ir >> 7) & 15) << 6) | (((ir >> 11) & 3) << 4)
                | (((ir >> 5) & 1) << 3) | (((ir >> 6) & 1) << 2);
            off = (((ir >> 5) & 1) << 6) | (((ir >> 10) & 7) << 3) | (((ir >> 6) & 1) << 2);
            case (f3)
                0: begin
                    e.instr = (imm << 20) | (2 << 15) | (rdp << 7) | 32'h13;
                    e.ill = (imm == 0);
                end
                2: e.instr = (off << 20) | (rs1p << 15) | (2 << 12) | (rdp << 7) | 32'h03;
                6: e.instr = ((off >> 5) << 25) | (rdp << 20) | (rs1p << 15) | (2 << 12)
                           | ((off & 31) << 7) | 32'h23;
                default: e.ill = 1'b1;
            endcase
        end
        return e;
    endfunction

    function automatic int modelCount();
        int n = pendQ.size();
        foreach (expQ[i]) n += expQ[i].hw;
        return n;
    endfunction

    task automatic modelPush(input logic [31:0] w);
        exp_t e;
        logic [15:0] h;
        if (modelSkip) begin
            pendQ.push_back(w[31:16]);
            modelSkip = 1'b0;
        end else begin
            pendQ.push_back(w[15:0]);
            pendQ.push_back(w[31:16]);
        end
        while (pendQ.size() > 0) begin
            h = pendQ[0];
            if (h[1:0] != 2'b11) begin
                e = refDecode(h, 16'h0, modelPc);
                void'(pendQ.pop_front());
            end else if (pendQ.size() >= 2) begin
                e = refDecode(h, pendQ[1], modelPc);
                void'(pendQ.pop_front());
                void'(pendQ.pop_front());
            end else begin
                break;
            end
            expQ.push_back(e);
            modelPc += 32'(e.hw * 2);
        end
    endtask

    task automatic modelReset();
        pendQ.delete();
        expQ.delete();
        modelPc = 32'h0;
        modelSkip = 1'b0;
    endtask

    // Monitor: state checks every cycle, instruction compare on every handshake.
    always @(negedge iCLK) begin
        exp_t e;
        if (iRST_N) begin
            check("count", 32'(oCOUNT), modelCount());
            check("f_ready", 32'(oF_READY), 32'(!iFLUSH && modelCount() <= BUF_HW - 2));
            check("d_valid", 32'(oD_VALID), 32'(expQ.size() > 0));
            if (oD_VALID && iD_READY && !iFLUSH && expQ.size() > 0) begin
                e = expQ.pop_front();
                check("instr", oD_INSTR, e.instr);
                check("pc", oD_PC, e.pc);
                check("is_c", 32'(oD_IS_C), 32'(e.isC));
                check("illegal", 32'(oD_ILLEGAL), 32'(e.ill));
                $display("pop pc=%h instr=%h is_c=%0d ill=%0d", oD_PC, oD_INSTR, oD_IS_C, oD_ILLEGAL);
            end
        end
    end

    // One clock of stimulus, entered and left at posedge+1.
    task automatic cyc(input logic fl, input logic [31:0] fpc, input logic fv,
                       input logic [31:0] w, input logic rdy, output logic acc);
        iFLUSH = fl; iFLUSH_PC = fpc; iF_VALID = fv; iF_WORD = w; iD_READY = rdy;
        @(negedge iCLK);
        acc = fv && oF_READY && !fl;
        @(posedge iCLK);
        #1;
        if (fl) begin
            pendQ.delete();
            expQ.delete();
            modelPc = fpc & ~32'h1;
            modelSkip = fpc[1];
        end else if (acc) begin
            modelPush(w);
        end
        iFLUSH = 1'b0; iF_VALID = 1'b0; iD_READY = 1'b0;
    endtask

    task automatic peek(input string nm, input logic [31:0] ins, input logic [31:0] pc,
                        input logic c, input logic ill);
        @(negedge iCLK);
        check({nm, "_valid"}, 32'(oD_VALID), 32'h1);
        check({nm, "_instr"}, oD_INSTR, ins);
        check({nm, "_pc"}, oD_PC, pc);
        check({nm, "_is_c"}, 32'(oD_IS_C), 32'(c));
        check({nm, "_ill"}, 32'(oD_ILLEGAL), 32'(ill));
        @(posedge iCLK);
        #1;
    endtask

    function automatic logic [31:0] randWord();
        logic [15:0] h0, h1;
        h0 = 16'($urandom);
        h1 = 16'($urandom);
        if ($urandom_range(0, 9) < 4) h0[1:0] = 2'b00;
        if ($urandom_range(0, 9) < 4) h1[1:0] = 2'b00;
        return {h1, h0};
    endfunction

    initial begin
        logic acc;
        logic [31:0] curWord;
        logic [31:0] fpc;

        #1;
        check("rst_count", 32'(oCOUNT), 32'h0);
        check("rst_valid", 32'(oD_VALID), 32'h0);
        check("rst_ready", 32'(oF_READY), 32'h1);
        repeat (2) @(posedge iCLK);
        #1 iRST_N = 1'b1;

        // CIW / CL expansion
        cyc(1, 32'h0, 0, 0, 0, acc);
        cyc(0, 0, 1, 32'h41440040, 0, acc);
        peek("addi4spn", 32'h00410413, 32'h0, 1, 0);
        cyc(0, 0, 0, 0, 1, acc);
        peek("c_lw", 32'h00452483, 32'h2, 1, 0);
        cyc(0, 0, 0, 0, 1, acc);

        // Illegal encodings
        cyc(0, 0, 1, 32'h00000000, 0, acc);
        peek("zero_lo", 32'h00010413, 32'h4, 1, 1);
        cyc(0, 0, 0, 0, 1, acc);
        peek("zero_hi", 32'h00010413, 32'h6, 1, 1);
        cyc(0, 0, 0, 0, 1, acc);
        cyc(0, 0, 1, 32'h00012000, 0, acc);
        peek("func3_001", 32'h00002000, 32'h8, 1, 1);
        cyc(0, 0, 0, 0, 1, acc);
        cyc(0, 0, 0, 0, 1, acc);

        // Straddle, then keep streaming until the pointers have wrapped
        cyc(1, 32'h102, 0, 0, 0, acc);
        cyc(0, 0, 1, 32'h04130001, 0, acc);
        @(negedge iCLK);
        check("straddle_hold", 32'(oD_VALID), 32'h0);
        @(posedge iCLK);
        #1;
        cyc(0, 0, 1, 32'h00010041, 0, acc);
        peek("straddle", 32'h00410413, 32'h102, 0, 0);
        cyc(0, 0, 0, 0, 1, acc);
        peek("after_straddle", 32'h00000001, 32'h106, 1, 0);
        cyc(0, 0, 0, 0, 1, acc);
        for (int i = 0; i < 12; i++) begin
            curWord = (i % 2 == 0) ? 32'h04130001 : 32'h00010041;
            acc = 1'b0;
            for (int k = 0; k < 8 && !acc; k++) cyc(0, 0, 1, curWord, 1, acc);
            check("wrap_accept", 32'(acc), 32'h1);
        end
        repeat (4) cyc(0, 0, 0, 0, 1, acc);

        // Backpressure until full, then drain
        cyc(1, 32'h0, 0, 0, 0, acc);
        curWord = randWord();
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 1, curWord, 0, acc);
            if (acc) curWord = randWord();
        end
        check("full_count", 32'(oCOUNT), 32'h4);
        check("full_ready", 32'(oF_READY), 32'h0);
        for (int i = 0; i < 12; i++) begin
            cyc(0, 0, 1, curWord, 1, acc);
            if (acc) curWord = randWord();
        end
        repeat (6) cyc(0, 0, 0, 0, 1, acc);
        check("drained_valid", 32'(oD_VALID), 32'h0);

        // Flush colliding with push and pop
        cyc(0, 0, 1, 32'h00010001, 0, acc);
        cyc(1, 32'h200, 1, 32'h00010001, 1, acc);
        check("flush_count", 32'(oCOUNT), 32'h0);
        check("flush_valid", 32'(oD_VALID), 32'h0);
        cyc(0, 0, 1, 32'h00010001, 0, acc);
        peek("flush_pc", 32'h00000001, 32'h200, 1, 0);
        repeat (2) cyc(0, 0, 0, 0, 1, acc);

        // Randomised traffic with occasional redirects
        curWord = randWord();
        for (int i = 0; i < 3000; i++) begin
            logic fl;
            fl  = ($urandom_range(0, 59) == 0);
            fpc = $urandom & 32'h0000FFFF;
            cyc(fl, fpc, $urandom_range(0, 9) < 7, curWord, $urandom_range(0, 9) < 6, acc);
            if (acc || fl) curWord = randWord();
        end

        // Asynchronous reset mid-stream with three halfwords held
        cyc(1, 32'h2, 0, 0, 0, acc);
        cyc(0, 0, 1, 32'h00010001, 0, acc);
        cyc(0, 0, 1, 32'h00410413, 0, acc);
        check("pre_reset_count", 32'(oCOUNT), 32'h3);
        #2 iRST_N = 1'b0;
        #1;
        check("async_rst_count", 32'(oCOUNT), 32'h0);
        check("async_rst_valid", 32'(oD_VALID), 32'h0);
        check("async_rst_ready", 32'(oF_READY), 32'h1);
        modelReset();
        @(posedge iCLK);
        #1 iRST_N = 1'b1;
        cyc(0, 0, 1, 32'h00010001, 0, acc);
        peek("post_reset", 32'h00000001, 32'h0, 1, 0);
        repeat (3) cyc(0, 0, 0, 0, 1, acc);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/rvc_fetch_expander.md
# rvc_fetch_expander

Parametrised fetch realignment buffer and RV32C quadrant-0 expander sitting between the instruction fetch port and the decode/ALU stage. It accepts 32-bit little-endian fetch words and buffers them as halfwords. It reassembles 32-bit instructions that straddle word boundaries, and presents one instruction per handshake with its PC. Quadrant-0 compressed instructions (CIW/CL/CS: c.addi4spn, c.lw, c.sw) are expanded to their RV32I equivalents; other compressed instructions are forwarded raw and flagged for the per-format C units.

## Interface

Parameters:

- XLEN, 32, PC width
- BUF_HW, 4, buffer depth in halfwords; power of two, ≥4
- EXPAND_Q0, 1, 1 = expand quadrant 0; 0 = forward quadrant 0 raw like Q1/Q2

Ports:

- iCLK  in  1  clock, rising edge
- iRST_N  in  1  asynchronous active-low reset
- iFLUSH  in  1  redirect; discard buffer, restart at iFLUSH_PC
- iFLUSH_PC  in  XLEN  redirect target; bit 0 ignored
- iF_VALID  in  1  fetch word valid
- iF_WORD  in  32  fetch word; [15:0] is the lower address
- oF_READY  out  1  buffer can accept a fetch word
- oD_VALID  out  1  instruction available
- iD_READY  in  1  decode accepts instruction
- oD_INSTR  out  32  expanded or raw instruction
- oD_PC  out  XLEN  address of oD_INSTR
- oD_IS_C  out  1  source was 16-bit
- oD_ILLEGAL  out  1  illegal quadrant-0 encoding
- oCOUNT  out  $clog2(BUF_HW+1)  halfwords held

## Operation

- **State:** a circular halfword buffer with head/tail pointers and a count, a head-PC register, and a skip flag.
- **Push:** occurs when iF_VALID & oF_READY.
  - Normally pushes [15:0] then [31:16], so count +2.
  - If skip=1, pushes only [31:16], so count +1, and clears skip.
- **Head classification:**
  - If head[1:0] != 2'b11, the instruction is compressed and needs 1 halfword.
  - Otherwise it is 32-bit and needs 2 halfwords: head is the low half, next is the high half.
- **Output valid:** oD_VALID = count ≥ need. A pop occurs when oD_VALID & iD_READY. On pop:
  - count drops by need.
  - oD_PC advances by 2 or 4.
- **32-bit instruction:** oD_INSTR is passed through, oD_IS_C=0, oD_ILLEGAL=0.
- **Compressed, Q1/Q2 (or Q0 with EXPAND_Q0=0):** oD_INSTR={16'h0,raw}, oD_IS_C=1, oD_ILLEGAL=0.
- **Compressed, Q0 with EXPAND_Q0=1:** oD_IS_C=1. Register fields are rd'=rs2'=8+IR[4:2] and rs1'=8+IR[9:7].
  - **c.addi4spn (func3 000):** imm10={IR[10:7],IR[12:11],IR[5],IR[6],2'b00}. Output is {2'b00,imm10,5'd2,3'b000,rd',7'h13}. imm10==0 → oD_ILLEGAL=1 (covers the all-zero halfword).
  - **c.lw (010):** off7={IR[5],IR[12:10],IR[6],2'b00}. Output is {5'b0,off7,rs1',3'b010,rd',7'h03}.
  - **c.sw (110):** Output is {5'b0,off7[6:5],rs2',rs1',3'b010,off7[4:0],7'h23}.
  - **func3 001/011/100/101/111:** oD_ILLEGAL=1, oD_INSTR={16'h0,raw}.
- **oD_INSTR/oD_IS_C/oD_ILLEGAL when oD_VALID=0:** don't-care. Bench checks them only while valid.
- **Flush:**
  - Next edge: count=0, head=tail=0, head PC={iFLUSH_PC[XLEN-1:1],1'b0}, skip=iFLUSH_PC[1].
  - Flush overrides a simultaneous push and pop; neither takes effect.
  - oF_READY=0 while iFLUSH=1.

## Timing

- **Reset (async, iRST_N low):** count=0, head/tail=0, head PC=0, skip=0. Consequently oD_VALID=0, oF_READY=1, oCOUNT=0.
- **oF_READY** = !iFLUSH & (count ≤ BUF_HW−2). It is computed from the registered count only; there is no pop-through bypass.
- **Latency:** a word pushed at edge N is visible on oD_* after edge N. The output path is combinational from buffer registers plus the expander, with no extra register.
- **Simultaneous push and pop:** allowed in the same cycle; count_next = count + pushed − popped.
- **Straddle:** a 32-bit instruction whose low half is the last buffered halfword holds oD_VALID=0 until the next push. The instruction is then valid in the following cycle.
- **Wrap-around:** pointers are modulo BUF_HW. A 32-bit instruction may span index BUF_HW−1 → 0.
- **Full:** with count ≥ BUF_HW−1, oF_READY=0. iF_VALID is ignored; the fetch side must hold its word.
- **Backpressure:** oD_VALID stays high and oD_* stay stable while iD_READY=0 with no flush.
- **Reset mid-operation:** all state is cleared immediately (asynchronous). A pending handshake is lost.

## Test plan

- **Reset:** assert iRST_N=0 mid-stream with count=3 → oCOUNT=0, oD_VALID=0, oF_READY=1 asynchronously. After release, the first fetch word appears with oD_PC=0.
- **CIW/CL expansion:** flush to 0x0. Push word 0x41440040.
  - Cycle 1 → oD_INSTR=0x00410413 (addi x8,x2,4), IS_C=1, PC=0x0.
  - Pop → oD_INSTR=0x00452483 (lw x9,4(x10)), PC=0x2.
- **Illegal encodings:** push word 0x00000000 → two instructions with oD_ILLEGAL=1. Push halfword 0x2000 (func3 001) → ILLEGAL=1, oD_INSTR=0x00002000.
- **Straddle + wrap:** flush to 0x102. Push 0x0413_0001 (only [31:16]=0x0413 kept). Next push 0x0001_0041.
  - Result → oD_INSTR=0x00410413, IS_C=0, PC=0x102.
  - Next, raw Q1 0x0001 → IS_C=1, PC=0x106.
  - Repeat the sequence until the pointers wrap past BUF_HW−1.
- **Backpressure/full:** hold iD_READY=0 with iF_VALID=1 → oF_READY falls when count reaches BUF_HW−1. oD_* are stable, and no words are lost after release.
- **Flush collision:** assert iFLUSH together with push and pop, iFLUSH_PC=0x200 → next cycle oCOUNT=0, oD_VALID=0. The next push yields oD_PC=0x200.
